// File: rtl/mt_sequencer_if.sv
// mt_sequencer_if: seed control, tempered-word stream and state-RAM bus of the MT sequencer
// Ports (master = sequencer side):
//   seed_req/seed            reseed request and value
//   busy                     seeding or twisting
//   out_valid/out_ready/out_data  tempered word stream
//   mem_raddr0..2/mem_rdata0..2   three 1-cycle-latency read ports
//   mem_we/mem_waddr/mem_wdata    single write port
interface mt_sequencer_if #(parameter int N = 624);
  localparam int IW = $clog2(N);
  logic seed_req;
  logic [31:0] seed;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic [IW-1:0] mem_raddr0, mem_raddr1, mem_raddr2;
  logic [31:0] mem_rdata0, mem_rdata1, mem_rdata2;
  logic mem_we;
  logic [IW-1:0] mem_waddr;
  logic [31:0] mem_wdata;
  modport master (
    input seed_req, seed, out_ready, mem_rdata0, mem_rdata1, mem_rdata2,
    output busy, out_valid, out_data, mem_raddr0, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata
  );
  modport slave (
    output seed_req, seed, out_ready, mem_rdata0, mem_rdata1, mem_rdata2,
    input busy, out_valid, out_data, mem_raddr0, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mt_sequencer.sv
// mt_sequencer: Mersenne-Twister control FSM sequencing seeding, in-place twist and tempered output
// Ports:
//   clk   clock
//   rst   synchronous reset, active-low (reloads DEFAULT_SEED)
//   bus   mt_sequencer_if.master: seed request, output stream, state-RAM read/write ports
module mt_sequencer #(
  parameter int N = 624,
  parameter int M = 397,
  parameter int R = 31,
  parameter logic [31:0] A = 32'h9908B0DF,
  parameter int U = 11,
  parameter logic [31:0] D = 32'hFFFFFFFF,
  parameter int S = 7,
  parameter logic [31:0] B = 32'h9D2C5680,
  parameter int T = 15,
  parameter logic [31:0] C = 32'hEFC60000,
  parameter int L = 18,
  parameter logic [31:0] F = 32'd1812433253,
  parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
  input logic clk,
  input logic rst,
  mt_sequencer_if.master bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NW = (IW+1)'(N);
  localparam logic [IW:0] LAST = (IW+1)'(N - 1);
  localparam logic [IW:0] MW = (IW+1)'(M);
  localparam logic [31:0] UPPER = ~((32'd1 << R) - 32'd1);
  typedef enum logic [1:0] {SEED, TWIST, SERVE_FETCH, SERVE_HOLD} state_t;
  state_t r_state;
  logic [IW:0] r_idx;
  logic [31:0] r_val;
  logic [IW:0] w_idx1;
  logic [IW-1:0] w_idxm, w_widx;
  logic w_rd, w_rd0;
  logic [31:0] w_y, w_twist, w_t0, w_t1, w_t2, w_t3, w_next_val;
  // w_idx1 wraps at N-1: serves as (c+1)%N in TWIST and as the next index in SEED/SERVE
  assign w_idx1 = r_idx == LAST ? '0 : r_idx + 1'b1;
  assign w_idxm = IW'(r_idx + MW >= NW ? r_idx + MW - NW : r_idx + MW);
  assign w_widx = IW'(r_idx - 1'b1);
  // TWIST runs N+1 cycles: reads in cycles 0..N-1, writes lag one cycle behind the reads
  assign w_rd = r_state == TWIST && r_idx != NW;
  assign w_rd0 = w_rd || r_state == SERVE_FETCH || r_state == SERVE_HOLD;
  assign w_y = (bus.mem_rdata0 & UPPER) | (bus.mem_rdata1 & ~UPPER);
  assign w_twist = bus.mem_rdata2 ^ (w_y >> 1) ^ (w_y[0] ? A : 32'd0);
  assign w_t0 = bus.mem_rdata0 ^ ((bus.mem_rdata0 >> U) & D);
  assign w_t1 = w_t0 ^ ((w_t0 << S) & B);
  assign w_t2 = w_t1 ^ ((w_t1 << T) & C);
  assign w_t3 = w_t2 ^ (w_t2 >> L);
  assign w_next_val = F * (r_val ^ (r_val >> 30)) + 32'(r_idx + 1'b1);
  assign bus.busy = r_state == SEED || r_state == TWIST;
  assign bus.out_valid = r_state == SERVE_HOLD;
  // raddr0 stays on idx through SERVE_HOLD, so rdata0 (and the tempered word) is stable while stalled
  assign bus.out_data = r_state == SERVE_HOLD ? w_t3 : '0;
  assign bus.mem_raddr0 = w_rd0 ? r_idx[IW-1:0] : '0;
  assign bus.mem_raddr1 = w_rd ? w_idx1[IW-1:0] : '0;
  assign bus.mem_raddr2 = w_rd ? w_idxm : '0;
  assign bus.mem_we = rst && (r_state == SEED || (r_state == TWIST && r_idx != '0));
  assign bus.mem_waddr = r_state == SEED ? r_idx[IW-1:0] : w_widx;
  assign bus.mem_wdata = r_state == SEED ? r_val : w_twist;
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= SEED;
      r_idx <= '0;
      r_val <= DEFAULT_SEED;
    end else if (bus.seed_req) begin
      r_state <= SEED;
      r_idx <= '0;
      r_val <= bus.seed;
    end else
      case (r_state)
        SEED: begin
          r_val <= w_next_val;
          r_idx <= w_idx1;
          r_state <= r_idx == LAST ? TWIST : SEED;
        end
        TWIST: begin
          r_idx <= r_idx == NW ? '0 : r_idx + 1'b1;
          r_state <= r_idx == NW ? SERVE_FETCH : TWIST;
        end
        SERVE_FETCH: r_state <= SERVE_HOLD;
        SERVE_HOLD:
          if (bus.out_ready) begin
            r_idx <= w_idx1;
            r_state <= r_idx == LAST ? TWIST : SERVE_FETCH;
          end
        default: r_state <= SEED;
      endcase
endmodule

// File: tb/tb_mt_sequencer.sv
// tb_mt_sequencer: scoreboard bench for mt_sequencer with a behavioural state RAM and reference MT19937
module tb_mt_sequencer;
  localparam int N = 624;
  localparam int M = 397;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mt_sequencer_if #(.N(N)) bus();
  mt_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    bus.mem_rdata0 <= ram[bus.mem_raddr0];
    bus.mem_rdata1 <= ram[bus.mem_raddr1];
    bus.mem_rdata2 <= ram[bus.mem_raddr2];
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
  end
  int n_cmp = 0;
  int n_bad = 0;
  int n_taken = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mt [0:N-1];
  int mti = N;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void m_seed(logic [31:0] s);
    mt[0] = s;
    for (int i = 1; i < N; i++) mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    mti = N;
  endfunction
  function automatic logic [31:0] m_next();
    logic [31:0] y;
    if (mti >= N) begin
      for (int k = 0; k < N; k++) begin
        y = (mt[k] & 32'h80000000) | (mt[(k+1)%N] & 32'h7FFFFFFF);
        mt[k] = mt[(k+M)%N] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'd0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction
  logic [31:0] prev_data = '0;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", bus.out_data, prev_data);
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word%0d: got %0d expected none", n_taken, bus.out_data);
      end else check($sformatf("word%0d", n_taken), bus.out_data, exp_q.pop_front());
      n_taken++;
    end
    prev_stall = rst && bus.out_valid && !bus.out_ready && !bus.seed_req;
    prev_data = bus.out_data;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  task automatic wait_taken(int target, int budget, bit rnd, string name);
    for (int i = 0; i < budget && n_taken < target; i++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (n_taken < target) begin
      n_bad++;
      $display("FAIL %s: taken %0d required %0d", name, n_taken, target);
    end
  endtask
  task automatic wait_valid(string name);
    for (int i = 0; i < 4000 && !bus.out_valid; i++) tick();
    check(name, 32'(bus.out_valid), 32'd1);
  endtask
  task automatic valid_timing(string name);
    for (int j = 1; j <= 2*N+2; j++) begin
      tick();
      if (j == 1) check({name, "_seed1"}, bus.mem_wdata, 32'd1301868182);
      if (j == 2*N) check({name, "_busy_twist"}, 32'(bus.busy), 32'd1);
      if (j == 2*N+1) begin
        check({name, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        check({name, "_busy_serve"}, 32'(bus.busy), 32'd0);
        check({name, "_we_serve"}, 32'(bus.mem_we), 32'd0);
      end
      if (j == 2*N+2) check({name, "_valid_on_time"}, 32'(bus.out_valid), 32'd1);
    end
  endtask
  task automatic push_default(int n);
    logic [31:0] w;
    m_seed(32'd5489);
    for (int i = 0; i < n; i++) begin
      w = m_next();
      exp_q.push_back(i == 0 ? 32'd3499211612 : i == 1 ? 32'd581869302 : i == 9999 ? 32'd4123659995 : w);
    end
  endtask
  int base;
  initial begin
    bus.seed_req = 1'b0;
    bus.seed = '0;
    bus.out_ready = 1'b0;
    push_default(10000);
    rst = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("seed0_we", 32'(bus.mem_we), 32'd1);
    check("seed0_addr", 32'(bus.mem_waddr), 32'd0);
    check("seed0_data", bus.mem_wdata, 32'd5489);
    valid_timing("t1");
    bus.out_ready = 1'b1;
    wait_taken(10000, 40000, 1'b0, "t2_drain");
    wait_valid("t3_valid_before");
    tick();
    bus.seed = 32'd1;
    bus.seed_req = 1'b1;
    tick();
    bus.seed_req = 1'b0;
    check("t3_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd1);
    exp_q.delete();
    m_seed(32'd1);
    void'(m_next());
    exp_q.push_back(32'd1791095845);
    exp_q.push_back(m_next());
    base = n_taken;
    bus.out_ready = 1'b1;
    wait_taken(base + 2, 4000, 1'b0, "t3_words");
    do_reset();
    push_default(2*N);
    base = n_taken;
    wait_taken(base + 2*N, 20000, 1'b1, "t4_throttle");
    do_reset();
    for (int j = 0; j < N + 200; j++) tick();
    check("t5_in_twist", 32'(bus.busy), 32'd1);
    do_reset();
    push_default(N);
    base = n_taken;
    bus.out_ready = 1'b1;
    valid_timing("t5");
    bus.out_ready = 1'b1;
    wait_taken(base + N - 1, 4000, 1'b0, "t6_prefix");
    wait_valid("t6_last_valid");
    bus.seed = 32'd42;
    bus.seed_req = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.seed_req = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_taken", 32'(n_taken - base), N);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_we", 32'(bus.mem_we), 32'd1);
    check("t6_waddr", 32'(bus.mem_waddr), 32'd0);
    check("t6_wdata", bus.mem_wdata, 32'd42);
    m_seed(32'd42);
    for (int i = 0; i < 3; i++) exp_q.push_back(m_next());
    base = n_taken;
    bus.out_ready = 1'b1;
    wait_taken(base + 3, 4000, 1'b0, "t6_reseed_words");
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
